crossing_reg_rx: RTL and testbench

- Destination-domain receiver for a multi-bit value driven from a source-domain crossing register.
- Source drives data plus a change toggle. This block synchronizes the toggle, captures the data once stable, and presents it to a consumer with a valid/dequeue handshake.
- Returns an acknowledge toggle so the source never changes data before capture.
- Sits entirely in the destination clock domain; the source block owns the other end.

---
 rtl/crossing_reg_rx.sv | 106 ++++++++++
 tb/tb_crossing_reg_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/crossing_reg_rx.sv
// Destination-side receiver of a toggle-handshake crossing register: synchronizes TOG_IN, captures D_IN, acks back.
// Optional sticky protocol-error flag built only when CROSSING_REG_RX_OVERRUN_CHECK_EN is defined.
module crossing_reg_rx #(
   parameter int unsigned      width      = 1,
   parameter logic [width-1:0] init       = {width{1'b0}},
   parameter int unsigned      syncStages = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [width-1:0] D_IN,
   input  logic             TOG_IN,
   output logic             ACK_OUT,
   output logic [width-1:0] Q_OUT,
   output logic             VALID_OUT,
   input  logic             DEQ,
   output logic             OVERRUN_OUT
);

   localparam int unsigned SS = (syncStages < 2) ? 2 : ((syncStages > 4) ? 4 : syncStages);

   logic [SS-1:0]    r_sync;
   logic             r_ack;
   logic [width-1:0] r_q;
   logic             r_valid;

   logic w_tsync;
   logic w_newd;
   logic w_buf_free;
   logic w_capture;

   assign w_tsync    = r_sync[SS-1];
   assign w_newd     = w_tsync ^ r_ack;
   assign w_buf_free = !r_valid || DEQ;
   assign w_capture  = w_newd && w_buf_free;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SS-2:0], TOG_IN};
      end
   end

   // D_IN is sampled only on the capture edge; the source holds it until it sees the ack flip.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_ack   <= 1'b0;
         r_q     <= init;
         r_valid <= 1'b0;
      end else if (w_capture) begin
         r_ack   <= ~r_ack;
         r_q     <= D_IN;
         r_valid <= 1'b1;
      end else if (DEQ && r_valid) begin
         r_valid <= 1'b0;
      end
   end

   assign ACK_OUT   = r_ack;
   assign Q_OUT     = r_q;
   assign VALID_OUT = r_valid;

`ifdef CROSSING_REG_RX_OVERRUN_CHECK_EN
   logic r_pending;
   logic r_tsync_d;
   logic r_seen;
   logic r_ovr;
   logic w_toggle;
   logic w_ovr_hit;

   assign w_toggle  = w_tsync ^ r_tsync_d;
   assign w_ovr_hit = w_toggle && (r_pending || r_seen);

   // r_seen marks a toggle not yet consumed by a capture; a second one is an overrun.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_pending <= 1'b0;
         r_tsync_d <= 1'b0;
         r_seen    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_tsync_d <= w_tsync;
         if (w_capture) begin
            r_pending <= 1'b0;
            r_seen    <= 1'b0;
         end else begin
            if (w_newd) r_pending <= 1'b1;
            if (w_toggle) r_seen <= 1'b1;
         end
         if (w_ovr_hit) r_ovr <= 1'b1;
      end
   end

   assign OVERRUN_OUT = r_ovr;

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (RST && w_ovr_hit && !r_ovr)
         $display("crossing_reg_rx: source overrun detected at time %0t", $time);
   end
`endif
`else
   assign OVERRUN_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_crossing_reg_rx.sv
// Randomized + directed bench for crossing_reg_rx, checked every cycle against a word-count reference model.
module tb_crossing_reg_rx;

   localparam int          W    = 8;
   localparam int          SS   = 2;
   localparam logic [W-1:0] INIT = 8'h5E;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic [W-1:0] D_IN = '0;
   logic         TOG_IN = 1'b0;
   logic         DEQ = 1'b0;
   logic         ACK_OUT;
   logic [W-1:0] Q_OUT;
   logic         VALID_OUT;
   logic         OVERRUN_OUT;

   crossing_reg_rx #(.width(W), .init(INIT), .syncStages(SS)) dut (
      .CLK(CLK), .RST(RST), .D_IN(D_IN), .TOG_IN(TOG_IN), .ACK_OUT(ACK_OUT),
      .Q_OUT(Q_OUT), .VALID_OUT(VALID_OUT), .DEQ(DEQ), .OVERRUN_OUT(OVERRUN_OUT)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: toggle samples seen at each edge, number of accepted words, held word.
   bit           hist[$];
   int           n_acc   = 0;
   bit           m_valid = 1'b0;
   logic [W-1:0] m_q     = INIT;

   function automatic void model_reset();
      hist.delete();
      n_acc   = 0;
      m_valid = 1'b0;
      m_q     = INIT;
   endfunction

   function automatic void model_edge();
      bit tsync;
      bit announced;
      if (!RST) begin
         model_reset();
         return;
      end
      tsync     = (hist.size() >= SS) ? hist[hist.size() - SS] : 1'b0;
      announced = (tsync != n_acc[0]);
      if (announced && (!m_valid || DEQ)) begin
         m_q     = D_IN;
         m_valid = 1'b1;
         n_acc++;
      end else if (DEQ && m_valid) begin
         m_valid = 1'b0;
      end
      hist.push_back(TOG_IN);
      if (hist.size() > 8) void'(hist.pop_front());
   endfunction

   always @(negedge RST) model_reset();

   always @(posedge CLK) begin
      model_edge();
      #1;
      chk("cyc_ack",   32'(ACK_OUT),   32'(n_acc % 2));
      chk("cyc_valid", 32'(VALID_OUT), 32'(m_valid));
      chk("cyc_q",     32'(Q_OUT),     32'(m_q));
`ifndef CROSSING_REG_RX_OVERRUN_CHECK_EN
      chk("cyc_ovr",   32'(OVERRUN_OUT), 32'd0);
`endif
   end

   task automatic after_edge();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge CLK);
      #2;
      chk("rst_q", 32'(Q_OUT), 32'h5E);
      chk("rst_valid", 32'(VALID_OUT), 32'd0);
      chk("rst_ack", 32'(ACK_OUT), 32'd0);
      chk("rst_ovr", 32'(OVERRUN_OUT), 32'd0);
      @(negedge CLK) RST = 1'b1;

      // First word: visible on the third edge after the toggle.
      @(negedge CLK) begin D_IN = 8'hA5; TOG_IN = 1'b1; end
      after_edge(); chk("lat_e1_valid", 32'(VALID_OUT), 32'd0);
      after_edge(); chk("lat_e2_valid", 32'(VALID_OUT), 32'd0);
      after_edge();
      chk("lat_e3_valid", 32'(VALID_OUT), 32'd1);
      chk("lat_e3_q", 32'(Q_OUT), 32'hA5);
      chk("lat_e3_ack", 32'(ACK_OUT), 32'd1);

      // Buffer full: new word is held off.
      @(negedge CLK) begin D_IN = 8'h3C; TOG_IN = 1'b0; end
      for (int i = 0; i < 10; i++) begin
         after_edge();
         chk("hold_q", 32'(Q_OUT), 32'hA5);
         chk("hold_ack", 32'(ACK_OUT), 32'd1);
      end
      @(negedge CLK) DEQ = 1'b1;
      after_edge();
      chk("deq_cap_q", 32'(Q_OUT), 32'h3C);
      chk("deq_cap_valid", 32'(VALID_OUT), 32'd1);
      chk("deq_cap_ack", 32'(ACK_OUT), 32'd0);

      // DEQ coincides with the first cycle newd is high.
      @(negedge CLK) begin DEQ = 1'b0; D_IN = 8'h5A; TOG_IN = 1'b1; end
      after_edge();
      after_edge();
      chk("sim_pre_valid", 32'(VALID_OUT), 32'd1);
      chk("sim_pre_ack", 32'(ACK_OUT), 32'd0);
      @(negedge CLK) DEQ = 1'b1;
      after_edge();
      chk("sim_q", 32'(Q_OUT), 32'h5A);
      chk("sim_valid", 32'(VALID_OUT), 32'd1);
      chk("sim_ack", 32'(ACK_OUT), 32'd1);
      @(negedge CLK) DEQ = 1'b0;
      for (int i = 0; i < 4; i++) begin
         after_edge();
         chk("sim_one_ack", 32'(ACK_OUT), 32'd1);
         chk("sim_keep_valid", 32'(VALID_OUT), 32'd1);
      end

      // Dequeue with nothing new, then again while empty.
      @(negedge CLK) DEQ = 1'b1;
      after_edge();
      chk("deq_empty_valid", 32'(VALID_OUT), 32'd0);
      chk("deq_empty_q", 32'(Q_OUT), 32'h5A);
      after_edge();
      chk("deq_idle_valid", 32'(VALID_OUT), 32'd0);
      chk("deq_idle_q", 32'(Q_OUT), 32'h5A);
      chk("deq_idle_ack", 32'(ACK_OUT), 32'd1);
      @(negedge CLK) DEQ = 1'b0;

      // Reset in the middle of a held word.
      @(negedge CLK) begin D_IN = 8'h11; TOG_IN = 1'b0; end
      repeat (3) after_edge();
      chk("pre_rst_q", 32'(Q_OUT), 32'h11);
      chk("pre_rst_ack", 32'(ACK_OUT), 32'd0);
      @(negedge CLK) begin D_IN = 8'h22; TOG_IN = 1'b1; end
      repeat (5) after_edge();
      chk("held_q", 32'(Q_OUT), 32'h11);
      chk("held_ack", 32'(ACK_OUT), 32'd0);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      chk("arst_q", 32'(Q_OUT), 32'h5E);
      chk("arst_valid", 32'(VALID_OUT), 32'd0);
      chk("arst_ack", 32'(ACK_OUT), 32'd0);
      TOG_IN = 1'b0;
      @(negedge CLK) RST = 1'b1;
      repeat (6) after_edge();
      chk("post_rst_valid", 32'(VALID_OUT), 32'd0);
      chk("post_rst_ack", 32'(ACK_OUT), 32'd0);

      // Source toggles twice while the buffer stays full.
      @(negedge CLK) begin D_IN = 8'h77; TOG_IN = 1'b1; end
      repeat (3) after_edge();
      chk("ovr_first_q", 32'(Q_OUT), 32'h77);
      @(negedge CLK) begin D_IN = 8'h88; TOG_IN = 1'b0; end
      repeat (4) after_edge();
      @(negedge CLK) TOG_IN = 1'b1;
      repeat (4) after_edge();
`ifdef CROSSING_REG_RX_OVERRUN_CHECK_EN
      chk("ovr_set", 32'(OVERRUN_OUT), 32'd1);
`else
      chk("ovr_off", 32'(OVERRUN_OUT), 32'd0);
`endif
      @(negedge CLK) DEQ = 1'b1;
      repeat (3) after_edge();
      chk("ovr_drain_valid", 32'(VALID_OUT), 32'd0);
`ifdef CROSSING_REG_RX_OVERRUN_CHECK_EN
      chk("ovr_sticky", 32'(OVERRUN_OUT), 32'd1);
`else
      chk("ovr_still_off", 32'(OVERRUN_OUT), 32'd0);
`endif

      // Random traffic from a protocol-obeying source and a random consumer.
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         if (i == 1500) begin
            RST = 1'b0;
            TOG_IN = 1'b0;
         end else if (i == 1503) begin
            RST = 1'b1;
         end
         DEQ = ($urandom_range(0, 2) != 0);
         if (RST && (TOG_IN == ACK_OUT) && ($urandom_range(0, 2) == 0)) begin
            D_IN   = 8'($urandom);
            TOG_IN = ~TOG_IN;
         end
      end
      @(negedge CLK) DEQ = 1'b0;
      repeat (2) @(posedge CLK);
      #2;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
